// File: rtl/coin_anim_ctrl.sv
// ---------------------------------------------------------------------------
// coin_anim_ctrl
//   Four-slot coin sprite controller. Each slot is FREE, SPIN or FADE, and
//   holds a top-left position, a 3-bit animation frame and a fade counter.
//   Coins are placed by spawn requests and collected by slot index. A
//   collected coin blinks for FADE_STEPS animation steps before its slot is
//   freed. Animation steps are derived from frame_start pulses divided by
//   FRAME_DIV. A per-pixel hit test picks the lowest-index drawable coin under
//   DrawX/DrawY and registers the sprite-strip address for it.
//
// Ports
//   vga_clk        : sole clock, rising edge
//   Reset          : synchronous, active-high reset
//   frame_start    : one-cycle pulse per video frame
//   DrawX, DrawY   : current pixel coordinate
//   blank          : high = visible pixel
//   spawn_valid    : place a coin at spawn_x/spawn_y
//   spawn_ready    : at least one slot is FREE (combinational)
//   collect_valid  : collect the coin in collect_slot
//   active_mask    : bit n set when slot n is not FREE (registered)
//   rom_address    : sprite-strip address of the hit pixel, 0 when no hit
//   pixel_hit      : a drawable coin covers the current visible pixel
//   hit_slot       : index of the winning slot, 0 when no hit
// ---------------------------------------------------------------------------
module coin_anim_ctrl #(
   parameter int FRAME_DIV  = 6,
   parameter int FADE_STEPS = 8
) (
   input  logic        vga_clk,
   input  logic        Reset,
   input  logic        frame_start,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   input  logic        blank,
   input  logic        spawn_valid,
   input  logic [9:0]  spawn_x,
   input  logic [9:0]  spawn_y,
   output logic        spawn_ready,
   input  logic        collect_valid,
   input  logic [1:0]  collect_slot,
   output logic [3:0]  active_mask,
   output logic [12:0] rom_address,
   output logic        pixel_hit,
   output logic [1:0]  hit_slot
);

   typedef enum logic [1:0] {
      S_FREE = 2'd0,
      S_SPIN = 2'd1,
      S_FADE = 2'd2
   } slot_state_e;

   localparam logic [5:0] DIV_LAST  = 6'(FRAME_DIV - 1);
   localparam logic [3:0] FADE_INIT = 4'(FADE_STEPS);

   // A fading coin is shown only on even counts, which makes it blink.
   function automatic logic slot_drawable(input slot_state_e st, input logic [3:0] fc);
      return (st == S_SPIN) || ((st == S_FADE) && (fc[0] == 1'b0));
   endfunction

   slot_state_e state_q [4];
   slot_state_e state_d [4];
   logic [9:0]  x_q     [4];
   logic [9:0]  x_d     [4];
   logic [9:0]  y_q     [4];
   logic [9:0]  y_d     [4];
   logic [2:0]  frame_q [4];
   logic [2:0]  frame_d [4];
   logic [3:0]  fade_q  [4];
   logic [3:0]  fade_d  [4];

   logic [5:0]  div_q;
   logic [5:0]  div_d;
   logic        step_tick;

   logic [3:0]  free_vec;
   logic [1:0]  spawn_sel;
   logic        spawn_fire;

   logic [10:0] dx_s [4];
   logic [10:0] dy_s [4];
   logic [3:0]  hit_vec;
   logic [1:0]  win_sel;

   logic [3:0]  active_mask_q;
   logic [3:0]  active_mask_d;
   logic [12:0] rom_address_q;
   logic [12:0] rom_address_d;
   logic        pixel_hit_q;
   logic        pixel_hit_d;
   logic [1:0]  hit_slot_q;
   logic [1:0]  hit_slot_d;

   // Free-slot detection and lowest-index spawn target selection.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         free_vec[i] = (state_q[i] == S_FREE);
      end
      spawn_ready = |free_vec;
      spawn_fire  = spawn_valid & spawn_ready;
      casez (free_vec)
         4'b???1: spawn_sel = 2'd0;
         4'b??10: spawn_sel = 2'd1;
         4'b?100: spawn_sel = 2'd2;
         4'b1000: spawn_sel = 2'd3;
         default: spawn_sel = 2'd0;
      endcase
   end

   // Frame divider: the pulse that wraps the count back to 0 is the step tick.
   always_comb begin
      div_d     = div_q;
      step_tick = 1'b0;
      if (frame_start) begin
         if (div_q >= DIV_LAST) begin
            div_d     = 6'd0;
            step_tick = 1'b1;
         end else begin
            div_d = div_q + 6'd1;
         end
      end else begin
         div_d = div_q;
      end
   end

   // Per-slot next state: spawn into FREE, collect from SPIN, age FADE on ticks.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         state_d[i] = state_q[i];
         x_d[i]     = x_q[i];
         y_d[i]     = y_q[i];
         frame_d[i] = frame_q[i];
         fade_d[i]  = fade_q[i];
         case (state_q[i])
            S_FREE: begin
               if (spawn_fire && (spawn_sel == 2'(i))) begin
                  state_d[i] = S_SPIN;
                  x_d[i]     = spawn_x;
                  y_d[i]     = spawn_y;
                  frame_d[i] = 3'd0;
                  fade_d[i]  = 4'd0;
               end else begin
                  state_d[i] = state_q[i];
               end
            end
            S_SPIN: begin
               if (step_tick) begin
                  frame_d[i] = frame_q[i] + 3'd1;
               end else begin
                  frame_d[i] = frame_q[i];
               end
               if (collect_valid && (collect_slot == 2'(i))) begin
                  state_d[i] = S_FADE;
                  fade_d[i]  = FADE_INIT;
               end else begin
                  state_d[i] = state_q[i];
               end
            end
            S_FADE: begin
               if (step_tick) begin
                  if (fade_q[i] == 4'd1) begin
                     state_d[i] = S_FREE;
                     fade_d[i]  = 4'd0;
                  end else begin
                     fade_d[i]  = fade_q[i] - 4'd1;
                     frame_d[i] = frame_q[i] + 3'd1;
                  end
               end else begin
                  state_d[i] = state_q[i];
               end
            end
            default: begin
               state_d[i] = S_FREE;
            end
         endcase
      end
      for (int i = 0; i < 4; i++) begin
         active_mask_d[i] = (state_d[i] != S_FREE);
      end
   end

   // Pixel hit test: 11-bit differences so a pixel left/above a coin goes negative.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         dx_s[i]    = {1'b0, DrawX} - {1'b0, x_q[i]};
         dy_s[i]    = {1'b0, DrawY} - {1'b0, y_q[i]};
         hit_vec[i] = slot_drawable(state_q[i], fade_q[i]) &&
                      (dx_s[i][10:5] == 6'd0) && (dy_s[i][10:5] == 6'd0);
      end
      casez (hit_vec)
         4'b???1: win_sel = 2'd0;
         4'b??10: win_sel = 2'd1;
         4'b?100: win_sel = 2'd2;
         4'b1000: win_sel = 2'd3;
         default: win_sel = 2'd0;
      endcase
      pixel_hit_d = blank & (|hit_vec);
      if (pixel_hit_d) begin
         hit_slot_d    = win_sel;
         // dy*256 + frame*32 + dx packs into disjoint bit fields
         rom_address_d = {dy_s[win_sel][4:0], frame_q[win_sel], dx_s[win_sel][4:0]};
      end else begin
         hit_slot_d    = 2'd0;
         rom_address_d = 13'd0;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge vga_clk) begin
      if (Reset) begin
         for (int i = 0; i < 4; i++) begin
            state_q[i] <= S_FREE;
            x_q[i]     <= 10'd0;
            y_q[i]     <= 10'd0;
            frame_q[i] <= 3'd0;
            fade_q[i]  <= 4'd0;
         end
         div_q         <= 6'd0;
         active_mask_q <= 4'd0;
         rom_address_q <= 13'd0;
         pixel_hit_q   <= 1'b0;
         hit_slot_q    <= 2'd0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            state_q[i] <= state_d[i];
            x_q[i]     <= x_d[i];
            y_q[i]     <= y_d[i];
            frame_q[i] <= frame_d[i];
            fade_q[i]  <= fade_d[i];
         end
         div_q         <= div_d;
         active_mask_q <= active_mask_d;
         rom_address_q <= rom_address_d;
         pixel_hit_q   <= pixel_hit_d;
         hit_slot_q    <= hit_slot_d;
      end
   end

   assign active_mask = active_mask_q;
   assign rom_address = rom_address_q;
   assign pixel_hit   = pixel_hit_q;
   assign hit_slot    = hit_slot_q;

endmodule
